// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store initiator; aligned 2 cycles to rsp, fault 1, split size+1 (LSU_MISALIGN_SPLIT_EN).
// Backpressure: req_ready only in IDLE; the response is held in RESP until rsp_ready.
module lsu_ctrl #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  rsp_cause,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   state_t      state, state_nx;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, data_q;
   logic [1:0]  cause_q;
   logic        accept, illegal, out_of_range, misaligned, last_beat;
   logic [2:0]  size;
   logic [32:0] last_byte;
   logic [1:0]  cause_nx;

   assign accept = req_valid && (state == IDLE);

   always_comb begin
      case (req_funct3[1:0])
         2'b01:   size = 3'd2;
         2'b10:   size = 3'd4;
         default: size = 3'd1;
      endcase
      illegal = req_we ? (req_funct3 > 3'd2)
                       : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
      // 33-bit sum so addresses near 2^32 cannot wrap back into range
      last_byte    = {1'b0, req_addr} + {30'd0, size} - 33'd1;
      out_of_range = last_byte >= MEM_LIMIT;
      misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      cause_nx = 2'd0;
      if (illegal)
         cause_nx = 2'd3;
      else if (out_of_range)
         cause_nx = 2'd2;
`ifndef LSU_MISALIGN_SPLIT_EN
      else if (misaligned)
         cause_nx = 2'd1;
`endif
   end

`ifdef LSU_MISALIGN_SPLIT_EN
   logic        split_q;
   logic [1:0]  cnt, last_idx;
   logic [31:0] asm_nx;

   assign last_idx  = (f3_q[1:0] == 2'b10) ? 2'd3 : ((f3_q[1:0] == 2'b01) ? 2'd1 : 2'd0);
   assign last_beat = !split_q || (cnt == last_idx);

   always_comb begin
      asm_nx = data_q;
      asm_nx[{cnt, 3'b000} +: 8] = mem_rdata[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         split_q <= 1'b0;
         cnt     <= 2'd0;
      end else if (accept) begin
         split_q <= misaligned && !illegal && !out_of_range;
         cnt     <= 2'd0;
      end else if (state == ACCESS && split_q) begin
         cnt <= cnt + 2'd1;
      end
   end
`else
   assign last_beat = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
         cause_q <= 2'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            data_q  <= 32'd0;
            cause_q <= cause_nx;
         end else if (state == ACCESS && !we_q) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (!split_q)
               data_q <= mem_rdata;
            else if (last_beat && f3_q == 3'b001)
               data_q <= {{16{asm_nx[15]}}, asm_nx[15:0]};
            else
               data_q <= asm_nx;
`else
            data_q <= mem_rdata;
`endif
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (cause_nx != 2'd0) ? RESP : ACCESS;
         ACCESS:  if (last_beat) state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      rsp_valid  = (state == RESP);
      rsp_rdata  = rsp_valid ? data_q : 32'd0;
      rsp_cause  = rsp_valid ? cause_q : 2'd0;
      rsp_err    = rsp_valid && (cause_q != 2'd0);
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_funct3 = 3'd0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      if (state == ACCESS) begin
         mem_read   = !we_q;
         mem_write  = we_q;
         mem_funct3 = f3_q;
         mem_addr   = addr_q;
         mem_wdata  = wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
         if (split_q) begin
            mem_funct3 = we_q ? 3'b000 : 3'b100;
            mem_addr   = addr_q + {30'd0, cnt};
            mem_wdata  = {24'd0, wdata_q[{cnt, 3'b000} +: 8]};
         end
`endif
      end
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array memory, directed scenarios and randomized requests against a byte-level model.
module tb_lsu_ctrl;
   localparam int MEM_BYTES = 1024;
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk, rst, clr;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_cause;
   logic        mem_read, mem_write;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;
   int nread = 0;
   int nwrite = 0;
   bit both_seen = 1'b0;
   logic [31:0] rd_addr_log [$];
   logic [2:0]  rd_f3_log [$];

   logic [7:0]  tb_mem  [MEM_BYTES];
   logic [7:0]  ref_mem [MEM_BYTES];
   logic [9:0]  a0;
   logic [31:0] word;

   lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_cause(rsp_cause),
      .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Data memory: combinational, extending read; write at posedge
   always_comb begin
      a0   = mem_addr[9:0];
      word = {tb_mem[a0 + 10'd3], tb_mem[a0 + 10'd2], tb_mem[a0 + 10'd1], tb_mem[a0]};
      case (mem_funct3)
         3'b000:  mem_rdata = {{24{word[7]}}, word[7:0]};
         3'b100:  mem_rdata = {24'd0, word[7:0]};
         3'b001:  mem_rdata = {{16{word[15]}}, word[15:0]};
         3'b101:  mem_rdata = {16'd0, word[15:0]};
         default: mem_rdata = word;
      endcase
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < MEM_BYTES; i++) tb_mem[10'(i)] <= 8'd0;
      end else if (mem_write) begin
         tb_mem[a0] <= mem_wdata[7:0];
         if (mem_funct3[1:0] != 2'b00) tb_mem[a0 + 10'd1] <= mem_wdata[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            tb_mem[a0 + 10'd2] <= mem_wdata[23:16];
            tb_mem[a0 + 10'd3] <= mem_wdata[31:24];
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_read) begin
            nread++;
            rd_addr_log.push_back(mem_addr);
            rd_f3_log.push_back(mem_funct3);
         end
         if (mem_write) nwrite++;
         if (mem_read && mem_write) both_seen = 1'b1;
      end
   end

   // Expected response straight from the ISA rules over a byte array
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] e_rdata,
                        output logic e_err, output logic [1:0] e_cause,
                        output int e_lat, output int e_nr, output int e_nw);
      int size;
      longint last;
      bit illegal, mis;
      logic [31:0] v;
      size    = 1 << f3[1:0];
      last    = longint'({32'd0, addr}) + longint'(size) - 1;
      illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      mis     = (addr % size) != 0;
      e_rdata = 32'd0; e_cause = 2'd0; e_lat = 1; e_nr = 0; e_nw = 0;
      if (illegal) e_cause = 2'd3;
      else if (last >= longint'(MEM_BYTES)) e_cause = 2'd2;
      else if (mis && !SPLIT) e_cause = 2'd1;
      else begin
         e_lat = mis ? size + 1 : 2;
         if (we) begin
            for (int i = 0; i < size; i++) ref_mem[10'(addr + i)] = wdata[8*i +: 8];
            e_nw = mis ? size : 1;
         end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[10'(addr + i)];
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            e_rdata = v;
            e_nr = mis ? size : 1;
         end
      end
      e_err = (e_cause != 2'd0);
   endtask

   // Issue one request from IDLE, measure latency and strobe counts, then release
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err, output logic [1:0] cause,
                         output int lat, output int nr, output int nw);
      int r0, w0;
      r0 = nread; w0 = nwrite;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata; err = rsp_err; cause = rsp_cause;
      nr = nread - r0; nw = nwrite - w0;
      repeat (hold) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready/rsp/rd/wr=%b%b%b%b expected 1000", req_ready, rsp_valid, mem_read, mem_write);
      end
      checks++;
      if ({rsp_rdata, rsp_err, rsp_cause, mem_funct3, mem_addr, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_data: rdata=%h err=%b cause=%0d f3=%0d addr=%h wdata=%h expected all 0",
                  rsp_rdata, rsp_err, rsp_cause, mem_funct3, mem_addr, mem_wdata);
      end
      repeat (2) @(posedge clk);
      #1; clr = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL reset_release: ready=%b rsp_valid=%b mem_addr=%h expected 1 0 0", req_ready, rsp_valid, mem_addr);
      end
   endtask

   task automatic test_aligned();
      logic [31:0] rd, ed; logic er, ee; logic [1:0] ca, ec; int lat, el, nr, enr, nw, enw;
      model(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ed, ee, ec, el, enr, enw);
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, ca, lat, nr, nw);
      checks++;
      if (er !== 1'b0 || lat != 2 || nw != 1 || nr != 0) begin
         errors++;
         $display("FAIL sw_aligned: err=%b lat=%0d wr=%0d rd=%0d expected 0 2 1 0", er, lat, nw, nr);
      end
      model(1'b0, 3'b010, 32'h10, 32'h0, ed, ee, ec, el, enr, enw);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, ca, lat, nr, nw);
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2 || nr != 1) begin
         errors++;
         $display("FAIL lw_aligned: data=%h err=%b lat=%0d rd=%0d expected deadbeef 0 2 1", rd, er, lat, nr);
      end
   endtask

   task automatic test_byte();
      logic [31:0] rd, ed; logic er, ee; logic [1:0] ca, ec; int lat, el, nr, enr, nw, enw;
      model(1'b1, 3'b000, 32'h20, 32'h00000080, ed, ee, ec, el, enr, enw);
      do_req(1'b1, 3'b000, 32'h20, 32'h00000080, 0, rd, er, ca, lat, nr, nw);
      model(1'b0, 3'b000, 32'h20, 32'h0, ed, ee, ec, el, enr, enw);
      do_req(1'b0, 3'b000, 32'h20, 32'h0, 0, rd, er, ca, lat, nr, nw);
      checks++;
      if (rd !== 32'hFFFFFF80) begin
         errors++;
         $display("FAIL lb_sext: data=%h expected ffffff80", rd);
      end
      model(1'b0, 3'b100, 32'h20, 32'h0, ed, ee, ec, el, enr, enw);
      do_req(1'b0, 3'b100, 32'h20, 32'h0, 0, rd, er, ca, lat, nr, nw);
      checks++;
      if (rd !== 32'h00000080) begin
         errors++;
         $display("FAIL lbu_zext: data=%h expected 00000080", rd);
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd, ed; logic er, ee; logic [1:0] ca, ec; int lat, el, nr, enr, nw, enw, q0;
      model(1'b1, 3'b010, 32'h20, 32'h11223344, ed, ee, ec, el, enr, enw);
      do_req(1'b1, 3'b010, 32'h20, 32'h11223344, 0, rd, er, ca, lat, nr, nw);
      model(1'b1, 3'b010, 32'h24, 32'h55667788, ed, ee, ec, el, enr, enw);
      do_req(1'b1, 3'b010, 32'h24, 32'h55667788, 0, rd, er, ca, lat, nr, nw);
      q0 = rd_addr_log.size();
      model(1'b0, 3'b010, 32'h21, 32'h0, ed, ee, ec, el, enr, enw);
      do_req(1'b0, 3'b010, 32'h21, 32'h0, 0, rd, er, ca, lat, nr, nw);
`ifdef LSU_MISALIGN_SPLIT_EN
      checks++;
      if (rd !== 32'h88112233 || er !== 1'b0 || lat != 5 || nr != 4) begin
         errors++;
         $display("FAIL lw_split: data=%h err=%b lat=%0d rd=%0d expected 88112233 0 5 4", rd, er, lat, nr);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rd_addr_log.size() <= q0 + k || rd_addr_log[q0+k] !== 32'h21 + 32'(k) || rd_f3_log[q0+k] !== 3'b100) begin
            errors++;
            $display("FAIL lw_split_beat%0d: log size=%0d expected LBU at %h", k, rd_addr_log.size(), 32'h21 + 32'(k));
         end
      end
`else
      checks++;
      if (rd !== 32'd0 || er !== 1'b1 || ca !== 2'd1 || nr != 0 || lat != 1) begin
         errors++;
         $display("FAIL lw_misaligned: data=%h err=%b cause=%0d rd=%0d lat=%0d expected 0 1 1 0 1", rd, er, ca, nr, lat);
      end
`endif
      checks++;
      if (rd !== ed || ca !== ec) begin
         errors++;
         $display("FAIL lw_misaligned_model: data=%h cause=%0d expected %h %0d (log base %0d)", rd, ca, ed, ec, q0);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; logic [1:0] ca; int lat, nr, nw;
      do_req(1'b0, 3'b010, 32'h3FE, 32'h0, 0, rd, er, ca, lat, nr, nw);
      checks++;
      if (er !== 1'b1 || ca !== 2'd2 || lat != 1 || nr != 0 || rd !== 32'd0) begin
         errors++;
         $display("FAIL lw_range: err=%b cause=%0d lat=%0d rd=%0d data=%h expected 1 2 1 0 0", er, ca, lat, nr, rd);
      end
      do_req(1'b0, 3'b011, 32'h0, 32'h0, 0, rd, er, ca, lat, nr, nw);
      checks++;
      if (er !== 1'b1 || ca !== 2'd3 || nr != 0) begin
         errors++;
         $display("FAIL load_f3_011: err=%b cause=%0d rd=%0d expected 1 3 0", er, ca, nr);
      end
      do_req(1'b1, 3'b100, 32'h21, 32'hFFFFFFFF, 0, rd, er, ca, lat, nr, nw);
      checks++;
      if (er !== 1'b1 || ca !== 2'd3 || nw != 0 || lat != 1) begin
         errors++;
         $display("FAIL store_f3_prio: err=%b cause=%0d wr=%0d lat=%0d expected 1 3 0 1", er, ca, nw, lat);
      end
   endtask

   task automatic test_hold();
      logic [31:0] ed; logic ee; logic [1:0] ec; int el, enr, enw, lat;
      model(1'b0, 3'b010, 32'h10, 32'h0, ed, ee, ec, el, enr, enw);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0;
      rsp_ready = 1'b1;   // ignored while no response is present
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      lat = 2;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      for (int c = 0; c < 6; c++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== ed || rsp_err !== 1'b0 || rsp_cause !== 2'd0 ||
             req_ready !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 32'd0 || mem_funct3 !== 3'd0) begin
            errors++;
            $display("FAIL hold_c%0d: vld=%b data=%h err=%b ready=%b rd=%b addr=%h expected 1 %h 0 0 0 0",
                     c, rsp_valid, rsp_rdata, rsp_err, req_ready, mem_read, mem_addr, ed);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, ed, a; logic er, ee; logic [1:0] ca, ec; int lat, el, nr, enr, nw, enw;
`ifdef LSU_MISALIGN_SPLIT_EN
      a = 32'h41;
`else
      a = 32'h40;
`endif
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = a; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      @(posedge clk); #1;
      ref_mem[10'h41] = 8'h0D;
      checks++;
      if (mem_write !== 1'b1 || mem_addr !== 32'h42 || mem_wdata !== 32'h000000F0) begin
         errors++;
         $display("FAIL split_beat2: wr=%b addr=%h wdata=%h expected 1 00000042 000000f0", mem_write, mem_addr, mem_wdata);
      end
`else
      checks++;
      if (mem_write !== 1'b1 || mem_addr !== 32'h40) begin
         errors++;
         $display("FAIL access_strobe: wr=%b addr=%h expected 1 00000040", mem_write, mem_addr);
      end
`endif
      rst = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || {rsp_valid, rsp_rdata, rsp_err, rsp_cause, mem_read, mem_write,
                                  mem_funct3, mem_addr, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_mid: ready=%b vld=%b wr=%b addr=%h wdata=%h expected ready 1 rest 0",
                  req_ready, rsp_valid, mem_write, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model(1'b0, 3'b010, 32'h40, 32'h0, ed, ee, ec, el, enr, enw);
      do_req(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, er, ca, lat, nr, nw);
      checks++;
      if (rd !== ed || er !== 1'b0 || lat != 2) begin
         errors++;
         $display("FAIL after_reset_lw: data=%h err=%b lat=%0d expected %h 0 2", rd, er, lat, ed);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, ed, addr, wd; logic er, ee, we; logic [1:0] ca, ec; logic [2:0] f3;
      int lat, el, nr, enr, nw, enw;
      logic [2:0] ld_codes [5];
      ld_codes[0] = 3'd0; ld_codes[1] = 3'd1; ld_codes[2] = 3'd2; ld_codes[3] = 3'd4; ld_codes[4] = 3'd5;
      for (int n = 0; n < 250; n++) begin
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = 3'($urandom_range(0, 2));
         else f3 = ld_codes[$urandom_range(0, 4)];
         if ($urandom_range(0, 4) == 0) addr = $urandom_range(MEM_BYTES - 8, MEM_BYTES + 4);
         else addr = $urandom_range(0, 63);
         wd = $urandom;
         model(we, f3, addr, wd, ed, ee, ec, el, enr, enw);
         do_req(we, f3, addr, wd, $urandom_range(0, 2), rd, er, ca, lat, nr, nw);
         checks++;
         if (er !== ee || ca !== ec) begin
            errors++;
            $display("FAIL rand%0d_status: we=%b f3=%0d addr=%h err=%b cause=%0d expected %b %0d", n, we, f3, addr, er, ca, ee, ec);
         end
         checks++;
         if (rd !== ed) begin
            errors++;
            $display("FAIL rand%0d_data: we=%b f3=%0d addr=%h data=%h expected %h", n, we, f3, addr, rd, ed);
         end
         checks++;
         if (lat != el || nr != enr || nw != enw) begin
            errors++;
            $display("FAIL rand%0d_timing: lat=%0d rd=%0d wr=%0d expected %0d %0d %0d", n, lat, nr, nw, el, enr, enw);
         end
      end
      checks++;
      if (both_seen !== 1'b0) begin
         errors++;
         $display("FAIL strobe_overlap: read and write seen together=%b expected 0", both_seen);
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      rsp_ready = 1'b0;
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[10'(i)] = 8'd0;
      #1;
      test_reset();
      test_aligned();
      test_byte();
      test_misaligned();
      test_errors();
      test_hold();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
